nios2_oci_mem_arbiter: RTL and testbench

- Shares one single-port on-chip-instrumentation (OCI) debug RAM between two requesters: JTAG debug commands and the CPU's Avalon debug-slave port.
- JTAG commands arrive as one-cycle take_action/take_no_action pulses plus the 38-bit jdo word, from the debug slave's sysclk-side logic.
- The block buffers one JTAG command, arbitrates round-robin, sequences RAM reads and writes, and returns read data to MonDReg (JTAG) or av_readdata (Avalon).

---
 rtl/nios2_oci_mem_arbiter_pkg.sv | 10 +
 rtl/nios2_oci_mem_arbiter_rr.sv | 26 ++
 rtl/nios2_oci_mem_arbiter.sv | 111 +++++++++++
 tb/tb_nios2_oci_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_mem_arbiter_pkg.sv
// nios2_oci_mem_arbiter_pkg: shared types and jdo field positions for the OCI RAM arbiter.
// Contents: FSM state enum, buffered JTAG command enum, grant enum, jdo field constants.
package oci_arb_pkg;
  typedef enum logic [1:0] {IDLE, J_RD, AV_RD} state_e;
  typedef enum logic [1:0] {J_ADDR, J_WR, J_RD_INC} jcmd_e;
  typedef enum logic {G_JTAG, G_AV} grant_e;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;
endpackage

// File: rtl/nios2_oci_mem_arbiter_rr.sv
// oci_arb_rr: two-requester round-robin grant between the JTAG slot and Avalon.
// Ports: clk, rst (sync, active-high), en (grant window), req_j/req_av requests,
//        gnt_j/gnt_av one-hot grants (combinational, valid only while en).
module oci_arb_rr
  import oci_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_j,
  input  logic req_av,
  output logic gnt_j,
  output logic gnt_av
);
  grant_e last_q, last_d;
  // On contention the requester that did not win last time gets the RAM.
  always_comb begin
    gnt_j  = en && req_j && (!req_av || last_q == G_AV);
    gnt_av = en && req_av && !gnt_j;
    last_d = gnt_j ? G_JTAG : gnt_av ? G_AV : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= G_AV;
    else last_q <= last_d;
  end
endmodule

// File: rtl/nios2_oci_mem_arbiter.sv
// nios2_oci_mem_arbiter: shares the single-port OCI debug RAM between JTAG commands and the Avalon debug slave.
// Ports: clk, reset (sync, active-high); jdo + take_* pulses (JTAG commands);
//        av_* Avalon slave; ram_* single-port RAM (read latency RD_LAT=1);
//        MonDReg (JTAG read data), jtag_overrun (sticky dropped-command flag).
// Build option: define OCI_ARB_BYTEENABLE_EN to honour av_byteenable on Avalon writes;
//               otherwise every write is full-word.
module nios2_oci_mem_arbiter
  import oci_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic              av_waitrequest,
  output logic [31:0]       av_readdata,
  output logic              av_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_overrun
);
  state_e state_q, state_d;
  jcmd_e cmd_q, cmd_d;
  logic slot_q, slot_d, rvalid_q, rvalid_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d, jaddr_q, jaddr_d;
  logic [31:0] sdata_q, sdata_d, rdata_q, rdata_d, mon_q, mon_d;
  logic en, gnt_j, gnt_av, any_pulse, multi, acc;
  logic [3:0] av_be;
  logic unused_ok;
`ifdef OCI_ARB_BYTEENABLE_EN
  assign av_be = av_byteenable;
`else
  assign av_be = 4'hF;
`endif
  assign unused_ok = ^{jdo, av_byteenable};
  oci_arb_rr u_rr (
    .clk    (clk),
    .rst    (reset),
    .en     (en),
    .req_j  (slot_q),
    .req_av (av_read | av_write),
    .gnt_j  (gnt_j),
    .gnt_av (gnt_av)
  );
  always_comb begin
    // Grants only from IDLE; an unsupported read latency keeps the arbiter parked.
    en        = state_q == IDLE && !reset && RD_LAT == 1;
    any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    multi     = (take_action_ocimem_a & take_action_ocimem_b) | (take_action_ocimem_a & take_no_action_ocimem_a) | (take_action_ocimem_b & take_no_action_ocimem_a);
    // The slot frees up in its own grant cycle, so a pulse landing then is still taken.
    acc       = any_pulse && (!slot_q || gnt_j);
    slot_d    = acc || (slot_q && !gnt_j);
    cmd_d     = !acc ? cmd_q : take_action_ocimem_a ? J_ADDR : take_action_ocimem_b ? J_WR : J_RD_INC;
    saddr_d   = acc ? jdo[JDO_ADDR_LSB +: ADDR_W] : saddr_q;
    sdata_d   = acc ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : sdata_q;
    // A drop in the same cycle as an accepted ocimem_a still leaves the flag set.
    ovr_d     = (any_pulse && !acc) || multi ? 1'b1 : (acc && take_action_ocimem_a) ? 1'b0 : ovr_q;
    jaddr_d   = !gnt_j ? jaddr_q : cmd_q == J_ADDR ? saddr_q : ADDR_W'(jaddr_q + 1'b1);
    state_d   = gnt_j && cmd_q != J_WR ? J_RD : gnt_av && av_read ? AV_RD : IDLE;
    rvalid_d  = state_q == AV_RD;
    rdata_d   = state_q == AV_RD ? ram_rdata : rdata_q;
    mon_d     = state_q == J_RD ? ram_rdata : mon_q;
    ram_addr  = gnt_av ? av_address : !gnt_j ? '0 : cmd_q == J_ADDR ? saddr_q : jaddr_q;
    ram_we    = (gnt_av && av_write) || (gnt_j && cmd_q == J_WR);
    ram_wdata = gnt_av ? av_writedata : sdata_q;
    ram_be    = !ram_we ? 4'h0 : gnt_av ? av_be : 4'hF;
    av_waitrequest = !gnt_av;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= J_ADDR;
      slot_q   <= 1'b0;
      saddr_q  <= '0;
      sdata_q  <= '0;
      jaddr_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      mon_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      slot_q   <= slot_d;
      saddr_q  <= saddr_d;
      sdata_q  <= sdata_d;
      jaddr_q  <= jaddr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      mon_q    <= mon_d;
      ovr_q    <= ovr_d;
    end
  end
  assign av_readdata      = rdata_q;
  assign av_readdatavalid = rvalid_q;
  assign MonDReg          = mon_q;
  assign jtag_overrun     = ovr_q;
endmodule

// File: tb/tb_nios2_oci_mem_arbiter.sv
// tb_nios2_oci_mem_arbiter: directed scoreboard bench for nios2_oci_mem_arbiter with a 1-cycle RAM model.
module tb_nios2_oci_mem_arbiter;
  typedef struct packed {logic [7:0] a; logic [31:0] d; logic [3:0] be;} wr_t;
`ifdef OCI_ARB_BYTEENABLE_EN
  localparam logic [3:0]  AV_BE_EXP = 4'b0011;
  localparam logic [31:0] EXP_FF    = 32'hC0DEA5A5;
`else
  localparam logic [3:0]  AV_BE_EXP = 4'hF;
  localparam logic [31:0] EXP_FF    = 32'hA5A5A5A5;
`endif
  logic clk = 1'b0, reset, mem_init;
  logic [37:0] jdo;
  logic take_a, take_b, take_n, av_read, av_write, av_waitrequest, av_readdatavalid, ram_we, jtag_overrun;
  logic [7:0] av_address, ram_addr;
  logic [31:0] av_writedata, av_readdata, ram_wdata, ram_rdata, MonDReg;
  logic [3:0] av_byteenable, ram_be;
  logic [31:0] mem [256];
  logic [31:0] rd_q [$];
  wr_t wr_q [$];
  wr_t w;
  int n_tests = 0, n_fail = 0;
  nios2_oci_mem_arbiter #(.ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b), .take_no_action_ocimem_a(take_n),
    .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_byteenable(av_byteenable), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata), .MonDReg(MonDReg), .jtag_overrun(jtag_overrun)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
    else if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (av_readdatavalid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", {31'b0, av_readdatavalid}, 32'h0);
      else chk("av_rdata", av_readdata, rd_q.pop_front());
    end
    if (ram_we) begin
      if (wr_q.size() == 0) chk("wr_unexpected", {31'b0, ram_we}, 32'h0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", {24'b0, ram_addr}, {24'b0, w.a});
        chk("wr_data", ram_wdata, w.d);
        chk("wr_be", {28'b0, ram_be}, {28'b0, w.be});
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  function automatic logic [37:0] jad(input logic [7:0] a);
    jad = 38'(a) << 17;
  endfunction
  function automatic logic [37:0] jdat(input logic [31:0] d);
    jdat = 38'(d) << 3;
  endfunction
  // k: 0 = ocimem_a (v = address), 1 = ocimem_b (v = data), 2 = no_action_ocimem_a.
  // Returns in the cycle where a JTAG read result is first visible on MonDReg.
  task automatic jcmd(input int k, input logic [31:0] v);
    tick;
    jdo = k == 1 ? jdat(v) : jad(v[7:0]);
    take_a = k == 0;
    take_b = k == 1;
    take_n = k == 2;
    tick;
    {take_a, take_b, take_n} = 3'b0;
    tick;
    tick;
  endtask
  // Avalon read granted while ocimem_a is captured, then ocimem_b arrives during AV_RD and is dropped.
  task automatic drop_seq(input logic [7:0] a, input logic [7:0] j);
    tick;
    av_read = 1'b1;
    av_address = a;
    take_a = 1'b1;
    jdo = jad(j);
    rd_q.push_back(32'hC0DE0000 | 32'(a));
    mid;
    chk("drop_av_gnt", {31'b0, av_waitrequest}, 32'h0);
    tick;
    av_read = 1'b0;
    take_a = 1'b0;
    take_b = 1'b1;
    jdo = jdat(32'h12345678);
    tick;
    take_b = 1'b0;
    mid;
    chk("ovr_set", {31'b0, jtag_overrun}, 32'h1);
    tick;
    tick;
    mid;
    chk("drop_mon", MonDReg, 32'hC0DE0000 | 32'(j));
    chk("ovr_hold", {31'b0, jtag_overrun}, 32'h1);
  endtask
  initial begin
    {take_a, take_b, take_n, av_read, av_write} = 5'b0;
    jdo = '0;
    av_address = '0;
    av_writedata = '0;
    av_byteenable = '0;
    reset = 1'b1;
    mem_init = 1'b1;
    repeat (3) tick;
    mid;
    chk("rst_wait", {31'b0, av_waitrequest}, 32'h1);
    chk("rst_valid", {31'b0, av_readdatavalid}, 32'h0);
    chk("rst_rdata", av_readdata, 32'h0);
    chk("rst_mon", MonDReg, 32'h0);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    chk("rst_addr", {24'b0, ram_addr}, 32'h0);
    chk("rst_be", {28'b0, ram_be}, 32'h0);
    chk("rst_ovr", {31'b0, jtag_overrun}, 32'h0);
    tick;
    reset = 1'b0;
    mem_init = 1'b0;
    wr_q.push_back('{8'h10, 32'hDEADBEEF, 4'hF});
    tick;
    take_a = 1'b1;
    jdo = jad(8'h10);
    tick;
    take_a = 1'b0;
    take_b = 1'b1;
    jdo = jdat(32'hDEADBEEF);
    tick;
    take_b = 1'b0;
    tick;
    tick;
    mid;
    chk("mon_prefetch", MonDReg, 32'hC0DE0010);
    chk("ovr_grant_accept", {31'b0, jtag_overrun}, 32'h0);
    tick;
    take_a = 1'b1;
    jdo = jad(8'h10);
    tick;
    take_a = 1'b0;
    tick;
    mid;
    chk("mon_early", MonDReg, 32'hC0DE0010);
    tick;
    mid;
    chk("mon_readback", MonDReg, 32'hDEADBEEF);
    tick;
    av_read = 1'b1;
    av_address = 8'h20;
    rd_q.push_back(32'hC0DE0020);
    mid;
    chk("av_rd_gnt", {31'b0, av_waitrequest}, 32'h0);
    tick;
    av_read = 1'b0;
    tick;
    tick;
    tick;
    take_n = 1'b1;
    tick;
    take_n = 1'b0;
    av_write = 1'b1;
    av_address = 8'hFF;
    av_writedata = 32'hA5A5A5A5;
    av_byteenable = 4'b0011;
    wr_q.push_back('{8'hFF, 32'hA5A5A5A5, AV_BE_EXP});
    mid;
    chk("cont_wait1", {31'b0, av_waitrequest}, 32'h1);
    tick;
    mid;
    chk("cont_wait2", {31'b0, av_waitrequest}, 32'h1);
    tick;
    mid;
    chk("cont_gnt", {31'b0, av_waitrequest}, 32'h0);
    tick;
    av_write = 1'b0;
    mid;
    chk("cont_mon", MonDReg, 32'hDEADBEEF);
    jcmd(0, 32'hFF);
    mid;
    chk("mon_ff_load", MonDReg, EXP_FF);
    jcmd(2, 32'h0);
    mid;
    chk("mon_ff_inc", MonDReg, EXP_FF);
    jcmd(2, 32'h0);
    mid;
    chk("mon_wrap", MonDReg, 32'hC0DE0000);
    drop_seq(8'h30, 8'h40);
    jcmd(2, 32'h0);
    mid;
    chk("mon_after_drop", MonDReg, 32'hC0DE0040);
    chk("ovr_after_n", {31'b0, jtag_overrun}, 32'h1);
    tick;
    av_read = 1'b1;
    av_address = 8'h20;
    tick;
    av_read = 1'b0;
    reset = 1'b1;
    mid;
    chk("rstrd_we", {31'b0, ram_we}, 32'h0);
    tick;
    mid;
    chk("rstrd_valid", {31'b0, av_readdatavalid}, 32'h0);
    chk("rstrd_rdata", av_readdata, 32'h0);
    chk("rstrd_mon", MonDReg, 32'h0);
    chk("rstrd_ovr", {31'b0, jtag_overrun}, 32'h0);
    chk("rstrd_wait", {31'b0, av_waitrequest}, 32'h1);
    chk("rstrd_addr", {24'b0, ram_addr}, 32'h0);
    tick;
    reset = 1'b0;
    jcmd(2, 32'h0);
    mid;
    chk("jaddr_rst", MonDReg, 32'hC0DE0000);
    drop_seq(8'h31, 8'h41);
    jcmd(0, 32'h50);
    mid;
    chk("ovr_clr", {31'b0, jtag_overrun}, 32'h0);
    chk("mon_50", MonDReg, 32'hC0DE0050);
    repeat (3) tick;
    chk("rd_q_empty", rd_q.size(), 32'h0);
    chk("wr_q_empty", wr_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
